// File: rtl/xyolo_int_sched_pkg.sv
// -----------------------------------------------------------------------------
// xyolo_int_sched_pkg
// Shared definitions for the internal-side YOLO write-stage sequencer:
//   - default parameter values for the sequencer and its interface
//   - FSM state encoding (exposed on the debug port)
//   - maxpool group size and pixel-alignment delay
//   - packed control word carried through the delay lines
// No ports (package).
// -----------------------------------------------------------------------------
package xyolo_int_sched_pkg;

   localparam int N_MACS_DEF    = 4;
   localparam int NVECT_DEF     = 4;
   localparam int RADDR_W_DEF   = 10;
   localparam int WADDR_W_DEF   = 10;
   localparam int CNT_W_DEF     = 16;
   localparam int XYOLO_LAT_DEF = 3;

   // Outputs pooled together into one write when maxpool is enabled.
   localparam int POOL_SIZE = 4;
   localparam int POOL_W    = $clog2(POOL_SIZE);

   // Cycles from vread_enB to the registered pixel at the xyolo input.
   localparam int ALIGN_DLY = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // One entry per read cycle; all-zero means "nothing in flight".
   typedef struct packed {
      logic acc;
      logic res;
      logic mp;
      logic wr;
   } ctrl_t;

   // Width of ld_nmac; never below 1 bit even when N_MACS is 1.
   function automatic int nmac_w(input int n_macs);
      return $clog2(n_macs) + (($clog2(n_macs) == 0) ? 1 : 0);
   endfunction

endpackage

// File: rtl/xyolo_int_sched_if.sv
// -----------------------------------------------------------------------------
// xyolo_int_sched_if
// Bundle between the run controller / configuration source and the sequencer,
// plus the sequencer's pixel-buffer read port, xyolo load controls and vwrite
// memory write port.
//
// Handshake: run is a single-cycle start pulse; it is accepted only in a cycle
// where done is high (sequencer idle) and is ignored otherwise. The cfg_*
// fields are sampled in the accepting cycle only. done stays low from the
// cycle after acceptance until the cycle after the last write enable.
//
// Modports:
//   master - controller side: drives run/cfg_*, observes everything else
//   slave  - sequencer side (xyolo_int_sched)
// -----------------------------------------------------------------------------
interface xyolo_int_sched_if #(
   parameter int N_MACS  = xyolo_int_sched_pkg::N_MACS_DEF,
   parameter int NVECT   = xyolo_int_sched_pkg::NVECT_DEF,
   parameter int RADDR_W = xyolo_int_sched_pkg::RADDR_W_DEF,
   parameter int WADDR_W = xyolo_int_sched_pkg::WADDR_W_DEF,
   parameter int CNT_W   = xyolo_int_sched_pkg::CNT_W_DEF
) ();

   localparam int N_MACS_W = xyolo_int_sched_pkg::nmac_w(N_MACS);

   logic                run;
   logic                done;
   logic [RADDR_W-1:0]  cfg_rd_start;
   logic [RADDR_W-1:0]  cfg_rd_incr;
   logic [RADDR_W-1:0]  cfg_rd_stride;
   logic [CNT_W-1:0]    cfg_n_inner;
   logic [CNT_W-1:0]    cfg_n_outer;
   logic [WADDR_W-1:0]  cfg_wr_start;
   logic [WADDR_W-1:0]  cfg_wr_incr;
   logic                cfg_maxpool;
   logic [N_MACS_W-1:0] cfg_nmac;
   logic [NVECT-1:0]    cfg_vect_mask;

   logic                vread_enB;
   logic [RADDR_W-1:0]  vread_addrB;
   logic                ld_acc;
   logic                ld_res;
   logic                ld_mp;
   logic [N_MACS_W-1:0] ld_nmac;
   logic [NVECT-1:0]    vwrite_enB;
   logic [WADDR_W-1:0]  vwrite_addrB;

   modport master (
      output run, cfg_rd_start, cfg_rd_incr, cfg_rd_stride, cfg_n_inner,
             cfg_n_outer, cfg_wr_start, cfg_wr_incr, cfg_maxpool, cfg_nmac,
             cfg_vect_mask,
      input  done, vread_enB, vread_addrB, ld_acc, ld_res, ld_mp, ld_nmac,
             vwrite_enB, vwrite_addrB
   );

   modport slave (
      input  run, cfg_rd_start, cfg_rd_incr, cfg_rd_stride, cfg_n_inner,
             cfg_n_outer, cfg_wr_start, cfg_wr_incr, cfg_maxpool, cfg_nmac,
             cfg_vect_mask,
      output done, vread_enB, vread_addrB, ld_acc, ld_res, ld_mp, ld_nmac,
             vwrite_enB, vwrite_addrB
   );

endinterface

// File: rtl/xyolo_ctrl_delay.sv
// -----------------------------------------------------------------------------
// xyolo_ctrl_delay
// Fixed-depth shift register for the sequencer's control word, with
// asynchronous clear.
// Ports:
//   clk, rst   - clock, async active-high clear
//   i_d        - word entering this cycle
//   o_q        - word delayed by DEPTH cycles
//   o_pending  - some non-zero word will still be inside after this clock
//                (input or any stage except the one leaving through o_q)
// -----------------------------------------------------------------------------
module xyolo_ctrl_delay #(
   parameter int DEPTH = 2,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q,
   output logic         o_pending
);

   logic [W-1:0] r_sr [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];

   // The last stage is excluded: it is being consumed in this cycle, which
   // lets the owner leave its drain state right after the final word.
   always_comb begin
      o_pending = |i_d;
      for (int i = 0; i < DEPTH - 1; i++) o_pending = o_pending | (|r_sr[i]);
   end

endmodule

// File: rtl/xyolo_int_sched.sv
// -----------------------------------------------------------------------------
// xyolo_int_sched
// Internal-side sequencer for the YOLO write stage. After a run pulse it walks
// the pixel buffer (one read per cycle, base/cur accumulators, addresses wrap
// modulo 2^RADDR_W), produces ld_acc/ld_res/ld_mp aligned with the registered
// pixel, and XYOLO_LAT+1 cycles after each qualifying ld_res issues a vwrite
// enable (cfg_vect_mask) at the current write address.
// Ports:
//   clk, rst     - clock, async active-high reset
//   bus          - xyolo_int_sched_if.slave (run/done, cfg_*, read port,
//                  load controls, write port)
//   o_dbg_state  - current FSM state
// -----------------------------------------------------------------------------
module xyolo_int_sched
   import xyolo_int_sched_pkg::*;
#(
   parameter int N_MACS    = N_MACS_DEF,
   parameter int NVECT     = NVECT_DEF,
   parameter int RADDR_W   = RADDR_W_DEF,
   parameter int WADDR_W   = WADDR_W_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int XYOLO_LAT = XYOLO_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   xyolo_int_sched_if.slave bus,
   output state_e           o_dbg_state
);

   localparam int N_MACS_W = nmac_w(N_MACS);

   state_e              r_state;
   state_e              w_state_nxt;

   // Shadow configuration, captured on an accepted run.
   logic [RADDR_W-1:0]  r_rd_incr;
   logic [RADDR_W-1:0]  r_rd_stride;
   logic [CNT_W-1:0]    r_n_inner;
   logic [CNT_W-1:0]    r_n_outer;
   logic [WADDR_W-1:0]  r_wr_incr;
   logic                r_maxpool;
   logic [N_MACS_W-1:0] r_nmac;
   logic [NVECT-1:0]    r_mask;

   // Walk state.
   logic [RADDR_W-1:0]  r_base;
   logic [RADDR_W-1:0]  r_cur;
   logic [CNT_W-1:0]    r_k;
   logic [CNT_W-1:0]    r_o;
   logic [POOL_W-1:0]   r_pool;
   logic [WADDR_W-1:0]  r_wr_addr;

   logic                w_start;
   logic                w_reading;
   logic                w_last_k;
   logic                w_last_o;
   logic                w_zero_cfg;
   logic                w_pend_a;
   logic                w_pend_b;
   logic                w_wr_fire;
   ctrl_t               w_ctrl_in;
   ctrl_t               w_ctrl_al;

   assign w_start    = (r_state == ST_IDLE) && bus.run;
   assign w_reading  = (r_state == ST_READ);
   assign w_last_k   = (r_k == (r_n_inner - CNT_W'(1)));
   assign w_last_o   = (r_o == (r_n_outer - CNT_W'(1)));
   assign w_zero_cfg = (bus.cfg_n_inner == '0) || (bus.cfg_n_outer == '0);

   // Control word for the read issued this cycle. With maxpool, ld_mp marks
   // the first output of a pool group and the write follows the last one.
   always_comb begin
      w_ctrl_in = '0;
      if (w_reading) begin
         w_ctrl_in.acc = (r_k == '0);
         w_ctrl_in.res = w_last_k;
         w_ctrl_in.mp  = w_last_k && (!r_maxpool || (r_pool == '0));
         w_ctrl_in.wr  = w_last_k &&
                         (!r_maxpool || (r_pool == POOL_W'(POOL_SIZE - 1)));
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         // An empty job still spends one cycle in DRAIN so done pulses low.
         ST_IDLE:  if (bus.run) w_state_nxt = w_zero_cfg ? ST_DRAIN : ST_READ;
         ST_READ:  if (w_last_k && w_last_o) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (!(w_pend_a || w_pend_b)) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_incr   <= '0;
         r_rd_stride <= '0;
         r_n_inner   <= '0;
         r_n_outer   <= '0;
         r_wr_incr   <= '0;
         r_maxpool   <= 1'b0;
         r_nmac      <= '0;
         r_mask      <= '0;
         r_base      <= '0;
         r_cur       <= '0;
         r_k         <= '0;
         r_o         <= '0;
         r_pool      <= '0;
         r_wr_addr   <= '0;
      end else begin
         if (w_wr_fire) r_wr_addr <= r_wr_addr + r_wr_incr;
         if (w_start) begin
            r_rd_incr   <= bus.cfg_rd_incr;
            r_rd_stride <= bus.cfg_rd_stride;
            r_n_inner   <= bus.cfg_n_inner;
            r_n_outer   <= bus.cfg_n_outer;
            r_wr_incr   <= bus.cfg_wr_incr;
            r_maxpool   <= bus.cfg_maxpool;
            r_nmac      <= bus.cfg_nmac;
            r_mask      <= bus.cfg_vect_mask;
            r_base      <= bus.cfg_rd_start;
            r_cur       <= bus.cfg_rd_start;
            r_k         <= '0;
            r_o         <= '0;
            r_pool      <= '0;
            r_wr_addr   <= bus.cfg_wr_start;
         end else if (w_reading) begin
            if (w_last_k) begin
               // Next output: cur jumps straight to the new base.
               r_k    <= '0;
               r_o    <= r_o + CNT_W'(1);
               r_base <= r_base + r_rd_stride;
               r_cur  <= r_base + r_rd_stride;
               r_pool <= r_pool + POOL_W'(1);
            end else begin
               r_k   <= r_k + CNT_W'(1);
               r_cur <= r_cur + r_rd_incr;
            end
         end
      end
   end

   // ------------------------------------------------------- delay lines
   // Stage A aligns the controls with the registered pixel; stage B covers
   // the xyolo latency plus the vwrite input register for the write strobe.
   xyolo_ctrl_delay #(
      .DEPTH (ALIGN_DLY),
      .W     ($bits(ctrl_t))
   ) u_align (
      .clk       (clk),
      .rst       (rst),
      .i_d       (w_ctrl_in),
      .o_q       (w_ctrl_al),
      .o_pending (w_pend_a)
   );

   xyolo_ctrl_delay #(
      .DEPTH (XYOLO_LAT + 1),
      .W     (1)
   ) u_lat (
      .clk       (clk),
      .rst       (rst),
      .i_d       (w_ctrl_al.wr),
      .o_q       (w_wr_fire),
      .o_pending (w_pend_b)
   );

   // ------------------------------------------------------------ outputs
   assign bus.done         = (r_state == ST_IDLE);
   assign bus.vread_enB    = w_reading;
   assign bus.vread_addrB  = r_cur;
   assign bus.ld_acc       = w_ctrl_al.acc;
   assign bus.ld_res       = w_ctrl_al.res;
   assign bus.ld_mp        = w_ctrl_al.mp;
   assign bus.ld_nmac      = (r_state != ST_IDLE) ? r_nmac : '0;
   assign bus.vwrite_enB   = w_wr_fire ? r_mask : '0;
   assign bus.vwrite_addrB = r_wr_addr;
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_xyolo_int_sched.sv
// -----------------------------------------------------------------------------
// tb_xyolo_int_sched
// Table of directed jobs with hand-computed timing (read/write counts, first
// write cycle, done-rise cycle, per-cycle ld_* bitmaps), read/write address
// scoreboards, plus hand sequences for busy-run, back-to-back run and reset
// in the middle of a job. Cycle 0 is the cycle in which run is high.
// -----------------------------------------------------------------------------
module tb_xyolo_int_sched;
   import xyolo_int_sched_pkg::*;

   localparam int RADDR_W = 10;
   localparam int WADDR_W = 10;

   logic   clk;
   logic   rst;
   state_e dbg_state;

   xyolo_int_sched_if bus ();

   xyolo_int_sched u_dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ------------------------------------------------ clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------- vectors
   typedef struct {
      int          n_inner;
      int          n_outer;
      int          rd_start;
      int          rd_incr;
      int          rd_stride;
      int          wr_start;
      int          wr_incr;
      bit          maxpool;
      logic [3:0]  mask;
      logic [1:0]  nmac;
      int          exp_reads;
      int          exp_writes;
      int          exp_first_wr;
      int          exp_done;
      logic [63:0] exp_acc;
      logic [63:0] exp_res;
      logic [63:0] exp_mp;
   } vec_t;

   vec_t  vecs[7];
   string names[7];

   int n_pass  = 0;
   int n_total = 0;

   logic [RADDR_W-1:0] exp_rd_q[$];
   logic [WADDR_W-1:0] exp_wr_q[$];

   function automatic vec_t mk(input int ni, input int no, input int rs,
                               input int ri, input int rstr, input int ws,
                               input int wi, input bit mp, input logic [3:0] m,
                               input logic [1:0] nm, input int er, input int ew,
                               input int efw, input int ed,
                               input logic [63:0] ea, input logic [63:0] eres,
                               input logic [63:0] emp);
      vec_t v;
      v.n_inner = ni;   v.n_outer = no;   v.rd_start = rs;  v.rd_incr = ri;
      v.rd_stride = rstr; v.wr_start = ws; v.wr_incr = wi;  v.maxpool = mp;
      v.mask = m;       v.nmac = nm;      v.exp_reads = er; v.exp_writes = ew;
      v.exp_first_wr = efw; v.exp_done = ed;
      v.exp_acc = ea;   v.exp_res = eres; v.exp_mp = emp;
      return v;
   endfunction

   // ---------------------------------------------------------- scoreboard
   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ------------------------------------------------------------ drivers
   task automatic apply_cfg(input vec_t v);
      bus.cfg_rd_start  = RADDR_W'(v.rd_start);
      bus.cfg_rd_incr   = RADDR_W'(v.rd_incr);
      bus.cfg_rd_stride = RADDR_W'(v.rd_stride);
      bus.cfg_n_inner   = 16'(v.n_inner);
      bus.cfg_n_outer   = 16'(v.n_outer);
      bus.cfg_wr_start  = WADDR_W'(v.wr_start);
      bus.cfg_wr_incr   = WADDR_W'(v.wr_incr);
      bus.cfg_maxpool   = v.maxpool;
      bus.cfg_nmac      = v.nmac;
      bus.cfg_vect_mask = v.mask;
   endtask

   task automatic scramble_cfg();
      bus.cfg_rd_start  = 10'd333;
      bus.cfg_rd_incr   = 10'd17;
      bus.cfg_rd_stride = 10'd99;
      bus.cfg_n_inner   = 16'd1;
      bus.cfg_n_outer   = 16'd1;
      bus.cfg_wr_start  = 10'd512;
      bus.cfg_wr_incr   = 10'd3;
      bus.cfg_maxpool   = 1'b1;
      bus.cfg_nmac      = 2'd1;
      bus.cfg_vect_mask = 4'b0001;
   endtask

   // Runs one job starting in the current cycle. at_neg: called at a negedge
   // (cycle 0 is sampled immediately). poke: cycle in which run is pulsed
   // again with scrambled config while busy (-1 = never).
   task automatic do_op(input vec_t v, input bit at_neg, input int poke,
                        input string tag);
      int          n_rd;
      int          n_wr;
      int          first_wr;
      int          done_cyc;
      int          nmac_bad;
      int          nw;
      logic [63:0] acc_m;
      logic [63:0] res_m;
      logic [63:0] mp_m;
      n_rd = 0; n_wr = 0; first_wr = -1; done_cyc = -1; nmac_bad = 0;
      acc_m = '0; res_m = '0; mp_m = '0;

      exp_rd_q.delete();
      exp_wr_q.delete();
      for (int o = 0; o < v.n_outer; o++)
         for (int k = 0; k < v.n_inner; k++)
            exp_rd_q.push_back(RADDR_W'(v.rd_start + o * v.rd_stride + k * v.rd_incr));
      nw = (v.n_inner == 0) ? 0 : (v.maxpool ? v.n_outer / 4 : v.n_outer);
      for (int i = 0; i < nw; i++)
         exp_wr_q.push_back(WADDR_W'(v.wr_start + i * v.wr_incr));

      apply_cfg(v);
      bus.run = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (!(c == 0 && at_neg)) @(negedge clk);
         if (c >= 1 && bus.done) begin
            done_cyc = c;
            break;
         end
         if (bus.ld_nmac !== ((c == 0) ? 2'd0 : v.nmac)) nmac_bad++;
         if (bus.vread_enB) begin
            n_rd++;
            if (exp_rd_q.size() > 0)
               check({tag, " rd_addr"}, 64'(bus.vread_addrB), 64'(exp_rd_q.pop_front()));
         end
         if (bus.vwrite_enB != '0) begin
            n_wr++;
            if (first_wr < 0) first_wr = c;
            check({tag, " wr_en"}, 64'(bus.vwrite_enB), 64'(v.mask));
            if (exp_wr_q.size() > 0)
               check({tag, " wr_addr"}, 64'(bus.vwrite_addrB), 64'(exp_wr_q.pop_front()));
         end
         if (c < 64) begin
            acc_m[c] = bus.ld_acc;
            res_m[c] = bus.ld_res;
            mp_m[c]  = bus.ld_mp;
         end
         @(posedge clk);
         #1;
         bus.run = (c + 1 == poke);
         if (c + 1 == poke) scramble_cfg();
      end

      check({tag, " done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
      check({tag, " reads"}, 64'(n_rd), 64'(v.exp_reads));
      check({tag, " writes"}, 64'(n_wr), 64'(v.exp_writes));
      check({tag, " first_wr"}, 64'(first_wr), 64'(v.exp_first_wr));
      check({tag, " ld_acc_map"}, acc_m, v.exp_acc);
      check({tag, " ld_res_map"}, res_m, v.exp_res);
      check({tag, " ld_mp_map"}, mp_m, v.exp_mp);
      check({tag, " ld_nmac_bad"}, 64'(nmac_bad), 64'd0);
      check({tag, " rd_left"}, 64'(exp_rd_q.size()), 64'd0);
      check({tag, " wr_left"}, 64'(exp_wr_q.size()), 64'd0);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int bad;
      //            ni no  rs   ri rstr ws   wi  mp mask     nm  rd wr fw  dn  acc        res        mp
      vecs[0] = mk(3, 2, 0,    1, 3,  100, 5,   0, 4'b1011, 2'd3, 6, 2, 9, 13, 64'h48,  64'h120,  64'h120);
      vecs[1] = mk(1, 8, 10,   1, 2,  0,   1,   1, 4'b0110, 2'd2, 8, 2, 10, 15, 64'h7F8, 64'h7F8,  64'h88);
      vecs[2] = mk(4, 1, 1022, 1, 0,  1023, 1,  0, 4'b1111, 2'd1, 4, 1, 10, 11, 64'h8,   64'h40,   64'h40);
      vecs[3] = mk(5, 0, 7,    1, 1,  0,   1,   0, 4'b1111, 2'd3, 0, 0, -1, 2, 64'h0,   64'h0,    64'h0);
      vecs[4] = mk(0, 3, 7,    1, 1,  0,   1,   0, 4'b1111, 2'd3, 0, 0, -1, 2, 64'h0,   64'h0,    64'h0);
      vecs[5] = mk(2, 5, 5,    3, 10, 200, 7,   1, 4'b0101, 2'd2, 10, 1, 14, 15, 64'hAA8, 64'h1550, 64'h1010);
      vecs[6] = mk(1, 3, 7,    1, 1,  50,  1020, 0, 4'b1000, 2'd1, 3, 3, 7, 10, 64'h38,  64'h38,   64'h38);
      names[0] = "basic";    names[1] = "maxpool8"; names[2] = "rd_wrap";
      names[3] = "outer0";   names[4] = "inner0";   names[5] = "pool_tail";
      names[6] = "wr_wrap";

      rst = 1'b1;
      bus.run = 1'b0;
      apply_cfg(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst done", 64'(bus.done), 64'd1);
      check("rst vread_en", 64'(bus.vread_enB), 64'd0);
      check("rst vread_addr", 64'(bus.vread_addrB), 64'd0);
      check("rst ld_acc", 64'(bus.ld_acc), 64'd0);
      check("rst ld_res", 64'(bus.ld_res), 64'd0);
      check("rst ld_mp", 64'(bus.ld_mp), 64'd0);
      check("rst ld_nmac", 64'(bus.ld_nmac), 64'd0);
      check("rst vwrite_en", 64'(bus.vwrite_enB), 64'd0);
      check("rst vwrite_addr", 64'(bus.vwrite_addrB), 64'd0);
      check("rst state", 64'(dbg_state), 64'(ST_IDLE));

      // Table-driven jobs.
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1;
         do_op(vecs[i], 1'b0, -1, names[i]);
      end

      // run pulsed (with different config) while busy: ignored.
      @(posedge clk);
      #1;
      do_op(vecs[0], 1'b0, 4, "busy_run");

      // run in the done-rise cycle: accepted.
      @(posedge clk);
      #1;
      do_op(vecs[5], 1'b0, -1, "b2b_first");
      do_op(vecs[6], 1'b1, -1, "b2b_second");

      // Reset in the middle of READ.
      @(posedge clk);
      #1;
      apply_cfg(vecs[0]);
      bus.run = 1'b1;
      @(posedge clk);
      #1;
      bus.run = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("mid pre ld_acc", 64'(bus.ld_acc), 64'd1);
      check("mid pre vread_en", 64'(bus.vread_enB), 64'd1);
      check("mid pre state", 64'(dbg_state), 64'(ST_READ));
      rst = 1'b1;
      #1;
      check("mid vread_en", 64'(bus.vread_enB), 64'd0);
      check("mid vread_addr", 64'(bus.vread_addrB), 64'd0);
      check("mid ld_acc", 64'(bus.ld_acc), 64'd0);
      check("mid ld_nmac", 64'(bus.ld_nmac), 64'd0);
      check("mid vwrite_addr", 64'(bus.vwrite_addrB), 64'd0);
      check("mid done", 64'(bus.done), 64'd1);
      #2;
      rst = 1'b0;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.vread_enB || bus.vwrite_enB != '0 || bus.ld_acc ||
             bus.ld_res || bus.ld_mp || !bus.done) bad++;
      end
      check("post_rst quiet", 64'(bad), 64'd0);
      @(posedge clk);
      #1;
      do_op(vecs[0], 1'b0, -1, "restart");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
